stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear sequencer for the stopwatch datapath. It takes the two debounced button levels and generates a 0.1 s count-enable strobe, a clear pulse, a lap-capture pulse and a display-select level. These outputs drive the stopwatch counter, the lap register and the display mux. It runs on the system clock and contains the tick prescaler, so the counter and display no longer need a derived clock.

---
 rtl/stopwatch_ctrl.sv | 98 +++++++++
 tb/tb_stopwatch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer with built-in 0.1 s tick prescaler and long-press clear
// Define STOPWATCH_LAP_TIMEOUT_EN to auto-release the lap view after LAP_HOLD_TICKS ticks
module stopwatch_ctrl #(
   parameter int TICK_DIV       = 10_000_000,
   parameter int LONG_CYCLES    = 200_000_000,
   parameter int LAP_HOLD_TICKS = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic       count_en,
   output logic       count_clr,
   output logic       lap_latch,
   output logic       show_lap,
   output logic [1:0] state
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10, LAP = 2'b11} state_t;
   state_t st, st_nx;
   logic start_q, start_p, lap_q, lap_p;
   logic [PW-1:0] pre, pre_nx;
   logic [HW-1:0] hold, hold_nx;
   logic ev_s, ev_ls, ev_ll, ev_to, run_now, run_nx, tick_nx, clr_nx, latch_nx;
   if (TICK_DIV < 2 || LONG_CYCLES < 2 || LAP_HOLD_TICKS < 1) begin : g_bad_cfg
      $error("stopwatch_ctrl: TICK_DIV and LONG_CYCLES must be >= 2, LAP_HOLD_TICKS >= 1");
   end
   // Buttons are sampled once, then edge-detected against the previous sample
   assign ev_s = start_q && !start_p;
   assign ev_ll = lap_q && hold == HOLD_LAST;
   assign ev_ls = !lap_q && lap_p && hold < HOLD_MAX;
   assign run_now = st == RUNNING || st == LAP;
   assign run_nx = st_nx == RUNNING || st_nx == LAP;
`ifdef STOPWATCH_LAP_TIMEOUT_EN
   localparam int TW = $clog2(LAP_HOLD_TICKS + 1);
   logic [TW-1:0] lap_ticks;
   always_ff @(posedge clk) begin
      if (rst || (st_nx == LAP && st != LAP))
         lap_ticks <= '0;
      else if (st == LAP && count_en)
         lap_ticks <= lap_ticks + 1'b1;
   end
   assign ev_to = st == LAP && count_en && lap_ticks == TW'(LAP_HOLD_TICKS - 1);
`else
   assign ev_to = 1'b0;
`endif
   always_comb begin
      st_nx = st;
      clr_nx = 1'b0;
      latch_nx = 1'b0;
      if (ev_ll) begin
         st_nx = IDLE;
         clr_nx = 1'b1;
      end else if (ev_s) begin
         st_nx = run_now ? PAUSED : RUNNING;
      end else if (ev_ls || ev_to) begin
         st_nx = st == RUNNING ? LAP : st == LAP ? RUNNING : IDLE;
         clr_nx = st == PAUSED;
         latch_nx = st == RUNNING;
      end
   end
   // Prescaler only advances across edges that stay in a counting state, so a pause keeps the fraction
   assign tick_nx = run_now && run_nx && pre == PRE_LAST;
   assign pre_nx = st_nx == IDLE ? '0 : !(run_now && run_nx) ? pre : pre == PRE_LAST ? '0 : pre + 1'b1;
   assign hold_nx = !lap_q ? '0 : hold == HOLD_MAX ? hold : hold + 1'b1;
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         pre <= '0;
         hold <= '0;
         count_en <= 1'b0;
         count_clr <= 1'b0;
         lap_latch <= 1'b0;
         show_lap <= 1'b0;
         start_q <= btn_start;
         start_p <= btn_start;
         lap_q <= btn_lap;
         lap_p <= btn_lap;
      end else begin
         st <= st_nx;
         pre <= pre_nx;
         hold <= hold_nx;
         count_en <= tick_nx;
         count_clr <= clr_nx;
         lap_latch <= latch_nx;
         show_lap <= st_nx == LAP;
         start_q <= btn_start;
         start_p <= start_q;
         lap_q <= btn_lap;
         lap_p <= lap_q;
      end
   end
   assign state = st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus randomized button traffic against a cycle model
module tb_stopwatch_ctrl;
   localparam int TD = 4, LC = 16, LH = 3;
   logic clk = 0, rst = 1, btn_start = 0, btn_lap = 0;
   logic count_en, count_clr, lap_latch, show_lap;
   logic [1:0] state;
   logic [5:0] dut_o;
   int errs = 0, checks = 0;
   int m_st = 0, m_frac = 0, m_hold = 0, m_laps = 0;
   bit m_en = 0, m_clr = 0, m_latch = 0, m_sq = 0, m_sp = 0, m_lq = 0, m_lp = 0;

   stopwatch_ctrl #(.TICK_DIV(TD), .LONG_CYCLES(LC), .LAP_HOLD_TICKS(LH)) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap),
      .count_en(count_en), .count_clr(count_clr), .lap_latch(lap_latch),
      .show_lap(show_lap), .state(state)
   );
   assign dut_o = {state, show_lap, lap_latch, count_clr, count_en};
   always #5 clk = ~clk;

   // Reference: states 0 idle, 1 running, 2 paused, 3 lap; m_frac = cycles elapsed toward next tick
   task automatic model_step();
      bit s, ls, ll, to, was_run, now_run;
      int nx;
      if (rst) begin
         m_st = 0; m_frac = 0; m_hold = 0; m_laps = 0;
         m_en = 0; m_clr = 0; m_latch = 0;
         m_sq = btn_start; m_sp = btn_start; m_lq = btn_lap; m_lp = btn_lap;
         return;
      end
      s = m_sq && !m_sp;
      ll = m_lq && m_hold + 1 == LC;
      ls = !m_lq && m_lp && m_hold < LC;
      to = 0;
`ifdef STOPWATCH_LAP_TIMEOUT_EN
      to = m_st == 3 && m_en && m_laps + 1 == LH;
`endif
      nx = m_st; m_clr = 0; m_latch = 0;
      if (ll) begin nx = 0; m_clr = 1; end
      else if (s) nx = (m_st == 1 || m_st == 3) ? 2 : 1;
      else if (ls || to) begin
         case (m_st)
            1: begin nx = 3; m_latch = 1; end
            2: begin nx = 0; m_clr = 1; end
            3: nx = 1;
            default: nx = 0;
         endcase
      end
      was_run = m_st == 1 || m_st == 3;
      now_run = nx == 1 || nx == 3;
      if (m_st == 3 && m_en) m_laps++;
      if (nx == 3 && m_st != 3) m_laps = 0;
      m_en = was_run && now_run && m_frac == TD - 1;
      m_frac = nx == 0 ? 0 : (was_run && now_run) ? (m_frac + 1) % TD : m_frac;
      m_hold = m_lq ? (m_hold + 1 > LC ? LC : m_hold + 1) : 0;
      m_sp = m_sq; m_sq = btn_start; m_lp = m_lq; m_lq = btn_lap;
      m_st = nx;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   function automatic logic [5:0] exp_o();
      return {m_st[1:0], m_st == 3, m_latch, m_clr, m_en};
   endfunction

   task automatic pulse_rst();
      rst = 1; btn_start = 0; btn_lap = 0;
      @(negedge clk);
      rst = 0;
      @(negedge clk);
   endtask

   task automatic press_start();
      btn_start = 1;
      @(negedge clk);
      btn_start = 0;
      @(negedge clk);
   endtask

   task automatic tap_lap(input int n);
      btn_lap = 1;
      repeat (n) @(negedge clk);
      btn_lap = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1; btn_start = 0; btn_lap = 0;
      repeat (3) @(negedge clk);
      checks++; if (dut_o !== 6'b0) begin errs++; $display("FAIL reset_outputs got=%b exp=000000", dut_o); end
      rst = 0;
      repeat (2) @(negedge clk);
      checks++; if (state !== 2'b00 || dut_o !== exp_o()) begin errs++; $display("FAIL reset_idle got=%b exp=%b", dut_o, exp_o()); end
   endtask

   task automatic test_start_tick();
      logic e;
      btn_start = 1;
      @(negedge clk);
      checks++; if (state !== 2'b00) begin errs++; $display("FAIL start_latency got=%b exp=00", state); end
      @(negedge clk);
      checks++; if (state !== 2'b01 || count_clr !== 1'b0) begin errs++; $display("FAIL start_run got=%b/%b exp=01/0", state, count_clr); end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) btn_start = 0;
         e = (k % 4 == 0);
         checks++; if (count_en !== e) begin errs++; $display("FAIL tick_k%0d got=%b exp=%b", k, count_en, e); end
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL model_start t=%0t got=%b exp=%b", $time, dut_o, exp_o()); end
      end
   endtask

   task automatic test_lap_short();
      btn_lap = 1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 5) btn_lap = 0;
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL model_lap t=%0t got=%b exp=%b", $time, dut_o, exp_o()); end
         if (k == 7) begin
            checks++; if (lap_latch !== 1'b1 || state !== 2'b11 || show_lap !== 1'b1) begin errs++; $display("FAIL lap_enter got=%b/%b/%b exp=1/11/1", lap_latch, state, show_lap); end
         end else begin
            checks++; if (lap_latch !== 1'b0) begin errs++; $display("FAIL lap_latch_width k=%0d got=%b exp=0", k, lap_latch); end
         end
      end
      btn_lap = 1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 2) btn_lap = 0;
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL model_lapx t=%0t got=%b exp=%b", $time, dut_o, exp_o()); end
         if (k == 4) begin
            checks++; if (state !== 2'b01 || show_lap !== 1'b0) begin errs++; $display("FAIL lap_exit got=%b/%b exp=01/0", state, show_lap); end
         end
      end
   endtask

   task automatic test_pause_resume_clear();
      bit ok;
      int n;
      for (int k = 0; k < 8 && m_frac != 1; k++) @(negedge clk);
      checks++; if (state !== 2'b01) begin errs++; $display("FAIL pause_sync got=%b exp=01", state); end
      press_start();
      checks++; if (state !== 2'b10) begin errs++; $display("FAIL pause_enter got=%b exp=10", state); end
      ok = 1;
      repeat (5) begin
         @(negedge clk);
         if (state !== 2'b10 || count_en !== 1'b0 || dut_o !== exp_o()) ok = 0;
      end
      checks++; if (!ok) begin errs++; $display("FAIL pause_frozen got=%b exp=10/no tick", dut_o); end
      press_start();
      checks++; if (state !== 2'b01) begin errs++; $display("FAIL resume_run got=%b exp=01", state); end
      @(negedge clk);
      checks++; if (count_en !== 1'b0) begin errs++; $display("FAIL resume_tick_early got=%b exp=0", count_en); end
      @(negedge clk);
      checks++; if (count_en !== 1'b1) begin errs++; $display("FAIL resume_tick_2clk got=%b exp=1", count_en); end
      press_start();
      checks++; if (state !== 2'b10) begin errs++; $display("FAIL pause_again got=%b exp=10", state); end
      btn_lap = 1; n = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) btn_lap = 0;
         n += int'(count_clr);
         if (k == 3) begin
            checks++; if (state !== 2'b00 || count_clr !== 1'b1) begin errs++; $display("FAIL clear_idle got=%b/%b exp=00/1", state, count_clr); end
         end
      end
      checks++; if (n != 1) begin errs++; $display("FAIL clear_once got=%0d exp=1", n); end
   endtask

   task automatic test_long_press();
      pulse_rst();
      press_start();
      btn_lap = 1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (k == 20) btn_lap = 0;
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL model_long t=%0t got=%b exp=%b", $time, dut_o, exp_o()); end
         if (k == 16) begin
            checks++; if (state !== 2'b01 || count_clr !== 1'b0) begin errs++; $display("FAIL long_early got=%b/%b exp=01/0", state, count_clr); end
         end else if (k == 17) begin
            checks++; if (state !== 2'b00 || count_clr !== 1'b1 || count_en !== 1'b0) begin errs++; $display("FAIL long_clear got=%b exp=00/clr/no tick", dut_o); end
         end else if (k > 17) begin
            checks++; if (state !== 2'b00 || count_clr !== 1'b0 || lap_latch !== 1'b0) begin errs++; $display("FAIL long_release_quiet k=%0d got=%b exp=000000", k, dut_o); end
         end
      end
   endtask

   task automatic test_priority();
      int n;
      press_start();
      checks++; if (state !== 2'b01) begin errs++; $display("FAIL prio_run got=%b exp=01", state); end
      btn_lap = 1; n = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 2) begin btn_lap = 0; btn_start = 1; end
         if (k == 3) btn_start = 0;
         n += int'(lap_latch);
         if (k == 4) begin
            checks++; if (state !== 2'b10) begin errs++; $display("FAIL prio_pause got=%b exp=10", state); end
         end
      end
      checks++; if (n != 0) begin errs++; $display("FAIL prio_no_latch got=%0d exp=0", n); end
   endtask

   task automatic test_reset_in_lap();
      bit ok;
      pulse_rst();
      press_start();
      tap_lap(2);
      checks++; if (state !== 2'b11) begin errs++; $display("FAIL rstlap_enter got=%b exp=11", state); end
      btn_start = 1; rst = 1;
      @(negedge clk);
      checks++; if (dut_o !== 6'b0) begin errs++; $display("FAIL rst_mid got=%b exp=000000", dut_o); end
      @(negedge clk);
      rst = 0;
      ok = 1;
      repeat (6) begin
         @(negedge clk);
         if (dut_o !== 6'b0 || dut_o !== exp_o()) ok = 0;
      end
      checks++; if (!ok) begin errs++; $display("FAIL rst_no_start_event got=%b exp=000000", dut_o); end
      btn_start = 0;
      @(negedge clk);
   endtask

   task automatic test_lap_timeout();
      int n;
      bit ok;
      pulse_rst();
      press_start();
      btn_lap = 1; n = 0; ok = 1;
`ifdef STOPWATCH_LAP_TIMEOUT_EN
      begin
         bit done;
         done = 0;
         for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (k == 2) btn_lap = 0;
            if (k == 4) begin
               checks++; if (state !== 2'b11) begin errs++; $display("FAIL timeout_enter got=%b exp=11", state); end
            end
            if (k > 4 && n == 3) begin
               checks++; if (state !== 2'b01 || show_lap !== 1'b0) begin errs++; $display("FAIL timeout_release got=%b/%b exp=01/0", state, show_lap); end
               done = 1;
            end else if (k >= 4 && state == 2'b11 && count_en == 1'b1) n++;
         end
         checks++; if (!done) begin errs++; $display("FAIL timeout_bound got=%0d ticks exp=3", n); end
      end
`else
      for (int k = 1; k <= 23; k++) begin
         @(negedge clk);
         if (k == 2) btn_lap = 0;
         if (k >= 4) begin
            if (state !== 2'b11 || show_lap !== 1'b1 || dut_o !== exp_o()) ok = 0;
            n += int'(count_en);
         end
      end
      checks++; if (!ok) begin errs++; $display("FAIL lap_persist got=%b exp=11/show", dut_o); end
      checks++; if (n != 5) begin errs++; $display("FAIL lap_tick_period got=%0d exp=5", n); end
`endif
   endtask

   task automatic test_random();
      rst = 0; btn_start = 0; btn_lap = 0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         checks++; if (dut_o !== exp_o()) begin errs++; $display("FAIL model_random t=%0t got=%b exp=%b", $time, dut_o, exp_o()); end
         rst = $urandom_range(0, 149) == 0;
         if ($urandom_range(0, 6) == 0) btn_start = ~btn_start;
         if ($urandom_range(0, 11) == 0) btn_lap = ~btn_lap;
      end
   endtask

   initial begin
      test_reset();
      test_start_tick();
      test_lap_short();
      test_pause_resume_clear();
      test_long_press();
      test_priority();
      test_reset_in_lap();
      test_lap_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t exp=finish", $time);
      $fatal(1);
   end
endmodule
